fetch_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register of the 5-stage RV32 pipeline. Holds the PC, issues one instruction-memory request at a time over a valid/ready handshake, and absorbs a response that arrives while Decode is stalled. Applies redirects from Execute and presents the fetched instruction to Decode. Consumes the hazard unit's StallF, StallD and FlushD, plus the branch outcome PCSrcE/PCTargetE.

---
 rtl/fetch_stage.sv | 189 ++++++++++++++++++
 tb/tb_fetch_stage.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : fetch_stage
//  Purpose  : Instruction-fetch stage and IF/ID pipeline register of the
//             5-stage RV32 pipeline. Holds the PC, keeps at most one
//             instruction-memory request in flight, parks a response that
//             arrives while Decode is stalled in a one-entry buffer, applies
//             Execute redirects and presents the fetched instruction to Decode.
//  Ports    :
//    clk, reset             clock / asynchronous active-high reset
//    StallF, StallD, FlushD hazard-unit controls
//    PCSrcE, PCTargetE      redirect from Execute (target word-aligned here)
//    imem_req_valid/ready   request handshake, imem_addr = PCF
//    imem_rsp_valid/data    instruction response
//    InstrD, PCD, PCPlus4D  IF/ID register contents
//    ValidD                 InstrD is a real (non-bubble) instruction
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);

    localparam logic [1:0]  S_IDLE    = 2'd0;  // free to issue
    localparam logic [1:0]  S_WAIT    = 2'd1;  // request accepted, response pending
    localparam logic [1:0]  S_DROP    = 2'd2;  // pending response belongs to a squashed path
    localparam logic [31:0] c_PC_STEP = 32'd4;
    localparam logic [31:0] c_ZERO    = 32'd0;
    localparam logic [31:0] c_ALIGN   = 32'hFFFF_FFFC;

    logic [1:0]  r_state;
    logic [1:0]  w_stateNext;
    logic [31:0] r_pcF;
    logic [31:0] r_pcPend;
    logic        r_bValid;
    logic [31:0] r_bInstr;
    logic [31:0] r_bPc;
    logic [31:0] r_instrD;
    logic [31:0] r_pcD;
    logic [31:0] r_pcPlus4D;
    logic        r_validD;

    logic        w_rspInWait;
    logic        w_consume;
    logic        w_reqValid;
    logic        w_accept;
    logic [31:0] w_target;

    // A live response for the outstanding request (not squashed by a redirect).
    assign w_rspInWait = (r_state == S_WAIT) & imem_rsp_valid & ~PCSrcE;
    // The live response goes straight into IF/ID this cycle, so a follow-on
    // request can be issued back-to-back without overrunning the buffer.
    assign w_consume   = w_rspInWait & ~FlushD & ~StallD & ~r_bValid;
    assign w_reqValid  = ~StallF & ~PCSrcE & ~r_bValid &
                         ((r_state == S_IDLE) | w_consume);
    assign w_accept    = w_reqValid & imem_req_ready;
    assign w_target    = PCTargetE & c_ALIGN;

    assign imem_req_valid = w_reqValid;
    assign imem_addr      = r_pcF;
    assign InstrD         = r_instrD;
    assign PCD            = r_pcD;
    assign PCPlus4D       = r_pcPlus4D;
    assign ValidD         = r_validD;

    // ------------------------------------------------------------------------
    // Request-tracking FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        if (PCSrcE) begin
            // A redirect squashes whatever is in flight: if the response is
            // here now it is simply ignored, otherwise it must be dropped later.
            case (r_state)
                S_WAIT, S_DROP: w_stateNext = imem_rsp_valid ? S_IDLE : S_DROP;
                default:        w_stateNext = S_IDLE;
            endcase
        end else if (w_accept) begin
            w_stateNext = S_WAIT;
        end else begin
            case (r_state)
                S_WAIT, S_DROP: if (imem_rsp_valid) w_stateNext = S_IDLE;
                S_IDLE:         w_stateNext = S_IDLE;
                default:        w_stateNext = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // PC and pending-request PC
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pcF    <= RESET_PC;
            r_pcPend <= c_ZERO;
        end else begin
            if (PCSrcE) begin
                r_pcF <= w_target;
            end else if (w_accept) begin
                r_pcF <= r_pcF + c_PC_STEP;
            end
            if (w_accept) begin
                r_pcPend <= r_pcF;
            end
        end
    end

    // ------------------------------------------------------------------------
    // One-entry skid buffer for a response that arrives while Decode stalls
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bValid <= 1'b0;
            r_bInstr <= c_ZERO;
            r_bPc    <= c_ZERO;
        end else if (PCSrcE) begin
            r_bValid <= 1'b0;
        end else if (w_rspInWait & StallD & ~FlushD) begin
            r_bValid <= 1'b1;
            r_bInstr <= imem_rsp_data;
            r_bPc    <= r_pcPend;
        end else if (r_bValid & ~FlushD & ~StallD) begin
            r_bValid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // IF/ID pipeline register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instrD   <= NOP_INSTR;
            r_pcD      <= c_ZERO;
            r_pcPlus4D <= c_ZERO;
            r_validD   <= 1'b0;
        end else if (FlushD) begin
            r_instrD   <= NOP_INSTR;
            r_pcD      <= c_ZERO;
            r_pcPlus4D <= c_ZERO;
            r_validD   <= 1'b0;
        end else if (StallD) begin
            r_instrD   <= r_instrD;
        end else if (r_bValid) begin
            // Buffered instruction is older than anything in flight.
            r_instrD   <= r_bInstr;
            r_pcD      <= r_bPc;
            r_pcPlus4D <= r_bPc + c_PC_STEP;
            r_validD   <= 1'b1;
        end else if (w_rspInWait) begin
            r_instrD   <= imem_rsp_data;
            r_pcD      <= r_pcPend;
            r_pcPlus4D <= r_pcPend + c_PC_STEP;
            r_validD   <= 1'b1;
        end else begin
            r_instrD   <= NOP_INSTR;
            r_pcD      <= c_ZERO;
            r_pcPlus4D <= c_ZERO;
            r_validD   <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_fetch_stage
//  Purpose  : Self-checking bench for fetch_stage. A behavioural instruction
//             memory answers each accepted request after a programmable
//             latency; expected Decode PCs are queued per scenario and a
//             monitor pops them as instructions leave the IF/ID register.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam logic [31:0] c_RESET_PC = 32'h0000_0100;
    localparam logic [31:0] c_NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        stallF;
    logic        stallD;
    logic        flushD;
    logic        pcSrcE;
    logic [31:0] pcTargetE;
    logic        imemReqValid;
    logic        imemReqReady;
    logic [31:0] imemAddr;
    logic        imemRspValid;
    logic [31:0] imemRspData;
    logic [31:0] instrD;
    logic [31:0] pcD;
    logic [31:0] pcPlus4D;
    logic        validD;

    int          checks = 0;
    int          errors = 0;
    int          rspLatency = 1;
    logic [31:0] expQ[$];

    fetch_stage #(
        .RESET_PC (c_RESET_PC),
        .NOP_INSTR(c_NOP)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .StallF        (stallF),
        .StallD        (stallD),
        .FlushD        (flushD),
        .PCSrcE        (pcSrcE),
        .PCTargetE     (pcTargetE),
        .imem_req_valid(imemReqValid),
        .imem_req_ready(imemReqReady),
        .imem_addr     (imemAddr),
        .imem_rsp_valid(imemRspValid),
        .imem_rsp_data (imemRspData),
        .InstrD        (instrD),
        .PCD           (pcD),
        .PCPlus4D      (pcPlus4D),
        .ValidD        (validD)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instrOf(input logic [31:0] a);
        return a ^ 32'hC0DE_0003;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Instruction memory: accept sampled mid-cycle, answer rspLatency cycles later.
    logic        havePend = 1'b0;
    int          pendCnt  = 0;
    logic [31:0] pendAddr = 32'h0;
    initial begin
        imemRspValid = 1'b0;
        imemRspData  = 32'h0;
        forever begin
            @(negedge clk);
            if (!reset && imemReqValid && imemReqReady) begin
                chk("one_outstanding", {31'b0, havePend}, 32'd0);
                pendAddr = imemAddr;
                pendCnt  = rspLatency;
                havePend = 1'b1;
            end
            @(posedge clk);
            #1;
            imemRspValid = 1'b0;
            if (reset) begin
                havePend = 1'b0;
            end else if (havePend) begin
                pendCnt--;
                if (pendCnt == 0) begin
                    imemRspValid = 1'b1;
                    imemRspData  = instrOf(pendAddr);
                    havePend     = 1'b0;
                end
            end
        end
    end

    // Scoreboard monitor: an instruction retires from ID when it is valid and
    // neither stalled nor flushed.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && validD && !stallD && !flushD) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_instr: actual PCD %h, required none", pcD);
                end else begin
                    e = expQ.pop_front();
                    chk("PCD", pcD, e);
                    chk("InstrD", instrD, instrOf(e));
                    chk("PCPlus4D", pcPlus4D, e + 32'd4);
                end
            end
        end
    end

    // Ends the previous scenario (queue must be drained), applies an
    // asynchronous reset and releases it just after a rising edge.
    task automatic doReset(input int lat);
        #2;
        chk("queue_empty", 32'(expQ.size()), 32'd0);
        expQ.delete();
        reset        = 1'b1;
        stallF       = 1'b0;
        stallD       = 1'b0;
        flushD       = 1'b0;
        pcSrcE       = 1'b0;
        pcTargetE    = 32'h0;
        imemReqReady = 1'b1;
        rspLatency   = lat;
        #1;
        chk("rst_InstrD", instrD, c_NOP);
        chk("rst_PCD", pcD, 32'h0);
        chk("rst_PCPlus4D", pcPlus4D, 32'h0);
        chk("rst_ValidD", {31'b0, validD}, 32'd0);
        chk("rst_addr", imemAddr, c_RESET_PC);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic nextCycle(input int c);
        if (c > 0) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        // ---- A: streaming at one instruction per cycle ----
        doReset(1);
        for (int k = 0; k < 6; k++) expQ.push_back(32'h100 + 32'(4 * k));
        for (int c = 0; c < 10; c++) begin
            nextCycle(c);
            if (c == 6) imemReqReady = 1'b0;
            @(negedge clk);
            if (c == 0) begin
                chk("A_reqv0", {31'b0, imemReqValid}, 32'd1);
                chk("A_addr0", imemAddr, 32'h100);
            end
            if (c == 1) begin
                chk("A_addr1", imemAddr, 32'h104);
                chk("A_valid1", {31'b0, validD}, 32'd0);
            end
            if (c == 2) begin
                chk("A_addr2", imemAddr, 32'h108);
                chk("A_valid2", {31'b0, validD}, 32'd1);
            end
        end

        // ---- B: memory not ready for three cycles at 0x104 ----
        doReset(1);
        expQ.push_back(32'h100);
        expQ.push_back(32'h104);
        expQ.push_back(32'h108);
        for (int c = 0; c < 9; c++) begin
            nextCycle(c);
            imemReqReady = (c == 0 || c == 4 || c == 5);
            @(negedge clk);
            if (c >= 1 && c <= 3) begin
                chk("B_addr_hold", imemAddr, 32'h104);
                chk("B_reqv_hold", {31'b0, imemReqValid}, 32'd1);
            end
            if (c == 3 || c == 4) chk("B_bubble", {31'b0, validD}, 32'd0);
        end

        // ---- C: Decode stalled while the 0x108 response arrives ----
        doReset(1);
        for (int k = 0; k < 4; k++) expQ.push_back(32'h100 + 32'(4 * k));
        for (int c = 0; c < 10; c++) begin
            nextCycle(c);
            imemReqReady = (c <= 6);
            stallD       = (c == 3 || c == 4);
            @(negedge clk);
            if (c >= 3 && c <= 5) chk("C_reqv_blocked", {31'b0, imemReqValid}, 32'd0);
            if (c == 4) chk("C_PCD_held", pcD, 32'h104);
            if (c == 6) begin
                chk("C_PCD_buf", pcD, 32'h108);
                chk("C_valid_buf", {31'b0, validD}, 32'd1);
                chk("C_reqv_after", {31'b0, imemReqValid}, 32'd1);
                chk("C_addr_after", imemAddr, 32'h10C);
            end
        end

        // ---- D: redirect while waiting, stale response dropped ----
        doReset(2);
        expQ.push_back(32'h200);
        for (int c = 0; c < 8; c++) begin
            nextCycle(c);
            imemReqReady = (c <= 4);
            pcSrcE       = (c == 1);
            pcTargetE    = (c == 1) ? 32'h203 : 32'h0;
            @(negedge clk);
            if (c == 1) chk("D_reqv_redirect", {31'b0, imemReqValid}, 32'd0);
            if (c == 2) begin
                chk("D_addr_target", imemAddr, 32'h200);
                chk("D_reqv_drop", {31'b0, imemReqValid}, 32'd0);
            end
            if (c == 3) begin
                chk("D_reqv_issue", {31'b0, imemReqValid}, 32'd1);
                chk("D_addr_issue", imemAddr, 32'h200);
            end
            if (c == 6) chk("D_valid_target", {31'b0, validD}, 32'd1);
        end

        // ---- E: redirect coincident with a response, plus FlushD ----
        doReset(1);
        expQ.push_back(32'h200);
        for (int c = 0; c < 7; c++) begin
            nextCycle(c);
            imemReqReady = (c <= 3);
            pcSrcE       = (c == 2);
            flushD       = (c == 2);
            pcTargetE    = (c == 2) ? 32'h200 : 32'h0;
            @(negedge clk);
            if (c == 2) chk("E_reqv_redirect", {31'b0, imemReqValid}, 32'd0);
            if (c == 3) begin
                chk("E_reqv_next", {31'b0, imemReqValid}, 32'd1);
                chk("E_addr_next", imemAddr, 32'h200);
                chk("E_flush_valid", {31'b0, validD}, 32'd0);
                chk("E_flush_instr", instrD, c_NOP);
                chk("E_flush_pc", pcD, 32'h0);
            end
        end

        // ---- F: PC wrap at the top of the address space ----
        doReset(1);
        expQ.push_back(32'hFFFF_FFFC);
        expQ.push_back(32'h0000_0000);
        for (int c = 0; c < 6; c++) begin
            nextCycle(c);
            imemReqReady = (c <= 2);
            pcSrcE       = (c == 0);
            pcTargetE    = (c == 0) ? 32'hFFFF_FFFC : 32'h0;
            @(negedge clk);
            if (c == 0) chk("F_reqv_redirect", {31'b0, imemReqValid}, 32'd0);
            if (c == 1) chk("F_addr_top", imemAddr, 32'hFFFF_FFFC);
            if (c == 2) chk("F_addr_wrap", imemAddr, 32'h0000_0000);
            if (c == 3) begin
                chk("F_PCD_top", pcD, 32'hFFFF_FFFC);
                chk("F_PCPlus4D_wrap", pcPlus4D, 32'h0000_0000);
            end
        end

        #2;
        chk("queue_empty_final", 32'(expQ.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
